// File: rtl/weight_load_ctrl_pkg.sv
// Shared configuration for the weight column loader: default sizes, state
// encoding and the counter width helper.
package weight_load_ctrl_pkg;

    localparam int DATASIZE    = 8;
    localparam int ARRAYHEIGHT = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOADED = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } wl_state_e;

    // Wide enough to hold DEPTH itself, not just DEPTH-1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 32'sd1);
    endfunction

endpackage

// File: rtl/weight_load_ctrl_ws_read_pipe.sv
// Aligns the weight buffer read strobe with its 1-cycle-late read data to
// produce the shift register load strobe and data word.
module ws_read_pipe #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rd_en_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              load_en_o,
    output logic [DATA_W-1:0] data_o
);

    logic load_en_q;

    // Delay the read strobe by one cycle to match the buffer latency.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            load_en_q <= 1'b0;
        end else begin
            load_en_q <= rd_en_i;
        end
    end

    // Read data is valid in the cycle the delayed strobe is high; gate it otherwise.
    always_comb begin
        data_o = '0;
        if (load_en_q) begin
            data_o = rdata_i;
        end else begin
            data_o = '0;
        end
    end

    assign load_en_o = load_en_q;

endmodule

// File: rtl/weight_load_ctrl.sv
// Fetches one weight column from the buffer into the column shift register and
// drains it into the PE column on request. Build option: WEIGHT_ASCEND_EN
// (when defined, fetch addresses descend so the drain delivers base first).
module weight_load_ctrl
    import weight_load_ctrl_pkg::*;
#(
    parameter int DATA_W = DATASIZE,
    parameter int DEPTH  = ARRAYHEIGHT,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              drain_req,
    output logic              busy,
    output logic              loaded,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ws_load_en,
    output logic [DATA_W-1:0] ws_in,
    output logic              ws_out_en
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    wl_state_e         state_q, state_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, loaded_q, done_q, ws_out_en_q;
    logic              load_en_s;
    logic [DATA_W-1:0] load_data_s;

    // Buffer address for the idx-th read of a column; wraps silently.
    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
                                                  input logic [CNT_W-1:0]  idx);
`ifdef WEIGHT_ASCEND_EN
        return b + ADDR_W'(CNT_LAST - idx);
`else
        return b + ADDR_W'(idx);
`endif
    endfunction

    // Next-state, counter and read-strobe logic.
    always_comb begin
        state_d     = state_q;
        rd_cnt_d    = rd_cnt_q;
        drain_cnt_d = drain_cnt_q;
        base_d      = base_q;
        mem_rd_en_d = 1'b0;
        mem_addr_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_FETCH;
                    base_d      = base_addr;
                    rd_cnt_d    = '0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = addr_of(base_addr, '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (mem_rd_en_q) begin
                    if (rd_cnt_q == CNT_LAST) begin
                        mem_rd_en_d = 1'b0;
                    end else begin
                        rd_cnt_d    = rd_cnt_q + CNT_W'(1);
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = addr_of(base_q, rd_cnt_q + CNT_W'(1));
                    end
                end else if (load_en_s) begin
                    // Reads finished and this is the final load beat.
                    state_d = ST_LOADED;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_LOADED: begin
                if (drain_req) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    state_d = ST_LOADED;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            rd_cnt_q    <= '0;
            drain_cnt_q <= '0;
            base_q      <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            busy_q      <= 1'b0;
            loaded_q    <= 1'b0;
            done_q      <= 1'b0;
            ws_out_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            base_q      <= base_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= (state_d != ST_IDLE);
            loaded_q    <= (state_d == ST_LOADED);
            done_q      <= (state_d == ST_DONE);
            ws_out_en_q <= (state_d == ST_DRAIN);
        end
    end

    ws_read_pipe #(
        .DATA_W (DATA_W)
    ) u_read_pipe (
        .clk_i     (clk),
        .rst_ni    (rst),
        .rd_en_i   (mem_rd_en_q),
        .rdata_i   (mem_rdata),
        .load_en_o (load_en_s),
        .data_o    (load_data_s)
    );

    assign busy       = busy_q;
    assign loaded     = loaded_q;
    assign done       = done_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign ws_load_en = load_en_s;
    assign ws_in      = load_data_s;
    assign ws_out_en  = ws_out_en_q;

endmodule

// File: tb/tb_weight_load_ctrl.sv
// Self-checking bench for weight_load_ctrl: per-cycle expectation tables for
// column fetches plus a LIFO shift-register model fed by a drain scoreboard.
module tb_weight_load_ctrl;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic          drain_req = 1'b0;
    logic          busy, loaded, done, mem_rd_en, ws_load_en, ws_out_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] ws_in;

    int n_pass = 0;
    int n_total = 0;

    logic [DW-1:0] stack_q[$];
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          rd_en;
        logic [AW-1:0] addr;
        logic          ld_en;
        logic [DW-1:0] wdata;
        logic          loaded;
        logic          busy;
    } vec_t;

    vec_t tbl[1:7];

    weight_load_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .drain_req  (drain_req),
        .busy       (busy),
        .loaded     (loaded),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .ws_load_en (ws_load_en),
        .ws_in      (ws_in),
        .ws_out_en  (ws_out_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Buffer model (buffer[a] = a[7:0], one-cycle latency) and LIFO shift register model.
    always @(posedge clk) begin
        logic [DW-1:0] v;
        mem_rdata <= mem_rd_en ? mem_addr[DW-1:0] : 8'h00;
        if (ws_load_en || ws_out_en) begin
            chk("load_out_mutex", {31'd0, ws_load_en & ws_out_en}, 32'd0);
        end
        if (ws_load_en) begin
            stack_q.push_back(ws_in);
        end
        if (ws_out_en) begin
            chk("stack_nonempty", {31'd0, stack_q.size() > 0}, 32'd1);
            chk("drain_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (stack_q.size() > 0 && exp_q.size() > 0) begin
                v = stack_q.pop_back();
                chk("drain_data", {24'd0, v}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, busy},       32'd0);
        chk({tag, "_loaded"}, {31'd0, loaded},     32'd0);
        chk({tag, "_done"},   {31'd0, done},       32'd0);
        chk({tag, "_rd_en"},  {31'd0, mem_rd_en},  32'd0);
        chk({tag, "_addr"},   {22'd0, mem_addr},   32'd0);
        chk({tag, "_ld_en"},  {31'd0, ws_load_en}, 32'd0);
        chk({tag, "_ws_in"},  {24'd0, ws_in},      32'd0);
        chk({tag, "_out_en"}, {31'd0, ws_out_en},  32'd0);
    endtask

    function automatic logic [AW-1:0] fetch_addr(input logic [AW-1:0] base, input int k);
        logic [AW-1:0] off;
`ifdef WEIGHT_ASCEND_EN
        off = AW'(DP - 1 - k);
`else
        off = AW'(k);
`endif
        return base + off;
    endfunction

    // Expected per-cycle outputs for cycles 1..7 after a start with the given base.
    task automatic fill_tbl(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int c = 1; c <= 7; c++) begin
            tbl[c] = '{rd_en: 1'b0, addr: '0, ld_en: 1'b0, wdata: '0, loaded: 1'b0, busy: 1'b1};
            if (c <= DP) begin
                tbl[c].rd_en = 1'b1;
                tbl[c].addr  = fetch_addr(base, c - 1);
            end
            if (c >= 2 && c <= DP + 1) begin
                a = fetch_addr(base, c - 2);
                tbl[c].ld_en = 1'b1;
                tbl[c].wdata = a[DW-1:0];
            end
            tbl[c].loaded = (c >= DP + 2);
        end
    endtask

    task automatic run_load(input logic [AW-1:0] base, input bit inject);
        fill_tbl(base);
        start = 1'b1;
        base_addr = base;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c == 3) begin
                start = 1'b0;
                drain_req = 1'b0;
            end
            chk($sformatf("c%0d_rd_en", c),  {31'd0, mem_rd_en},  {31'd0, tbl[c].rd_en});
            chk($sformatf("c%0d_addr", c),   {22'd0, mem_addr},   {22'd0, tbl[c].addr});
            chk($sformatf("c%0d_ld_en", c),  {31'd0, ws_load_en}, {31'd0, tbl[c].ld_en});
            chk($sformatf("c%0d_ws_in", c),  {24'd0, ws_in},      {24'd0, tbl[c].wdata});
            chk($sformatf("c%0d_loaded", c), {31'd0, loaded},     {31'd0, tbl[c].loaded});
            chk($sformatf("c%0d_busy", c),   {31'd0, busy},       {31'd0, tbl[c].busy});
            if (inject && c == 2) begin
                start = 1'b1;
                base_addr = 10'h200;
                drain_req = 1'b1;
            end
        end
    endtask

    task automatic push_drain_exp(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int i = 0; i < DP; i++) begin
`ifdef WEIGHT_ASCEND_EN
            a = base + AW'(i);
`else
            a = base + AW'(DP - 1 - i);
`endif
            exp_q.push_back(a[DW-1:0]);
        end
    endtask

    task automatic run_drain(input logic [AW-1:0] base, input bit try_start_in_done);
        push_drain_exp(base);
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        for (int i = 1; i <= DP; i++) begin
            chk($sformatf("drain%0d_out_en", i), {31'd0, ws_out_en},  32'd1);
            chk($sformatf("drain%0d_ld_en", i),  {31'd0, ws_load_en}, 32'd0);
            chk($sformatf("drain%0d_done", i),   {31'd0, done},       32'd0);
            tick();
        end
        chk("done_pulse",  {31'd0, done},      32'd1);
        chk("done_out_en", {31'd0, ws_out_en}, 32'd0);
        if (try_start_in_done) begin
            start = 1'b1;
            base_addr = 10'h155;
        end
        tick();
        start = 1'b0;
        chk("post_done_busy",  {31'd0, busy},      32'd0);
        chk("post_done_done",  {31'd0, done},      32'd0);
        chk("post_done_rd_en", {31'd0, mem_rd_en}, 32'd0);
        tick();
        chk("idle2_busy",  {31'd0, busy},      32'd0);
        chk("idle2_rd_en", {31'd0, mem_rd_en}, 32'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset then idle.
        rst = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b1;
        tick();
        chk_all_zero("post_reset");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy",  {31'd0, busy},      32'd0);
            chk("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
        end

        // Basic column load, wait in LOADED, drain (start in DONE ignored).
        run_load(10'h010, 1'b0);
        tick();
        chk("loaded_hold", {31'd0, loaded}, 32'd1);
        run_drain(10'h010, 1'b1);

        // Address wrap with ignored start/drain_req during FETCH.
        run_load(10'h3FE, 1'b1);
        run_drain(10'h3FE, 1'b0);

        // Reset during the second drain cycle.
        run_load(10'h010, 1'b0);
        push_drain_exp(10'h010);
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        chk("mid_drain_out_en", {31'd0, ws_out_en}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        stack_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        rst = 1'b1;
        tick();
        chk("after_rst_done", {31'd0, done}, 32'd0);
        chk("after_rst_busy", {31'd0, busy}, 32'd0);
        run_load(10'h010, 1'b0);
        run_drain(10'h010, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
